// File: rtl/irq_pending_ctrl_if.sv
// Bus bundle between the request-capture stage, its priority encoder and the consumer.
// The slave modport is the capture stage; the master modport is everything around it.
interface irq_pending_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       req;
    logic [3:0]       mask;
    logic [3:0]       enc_in;
    logic [1:0]       enc_out;
    logic             enc_valid;
    logic             irq_valid;
    logic [1:0]       irq_id;
    logic             irq_ready;
    logic             clr_cnt;
    logic [CNT_W-1:0] missed_cnt;

    modport slave (
        input  req, mask, enc_out, enc_valid, irq_ready, clr_cnt,
        output enc_in, irq_valid, irq_id, missed_cnt
    );

    modport master (
        output req, mask, enc_out, enc_valid, irq_ready, clr_cnt,
        input  enc_in, irq_valid, irq_id, missed_cnt
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Sticky pending latch for four event lines, masked into an external priority encoder,
// with the winning index offered to a consumer over valid/ready and a missed-event counter.
module irq_pending_ctrl #(
    parameter int CNT_W     = 8,
    parameter bit EDGE_MODE = 1'b1
) (
    input logic               clk,
    input logic               rst,
    irq_pending_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       req_q;
    logic [3:0]       pend_q, pend_d;
    logic [1:0]       irq_id_q, irq_id_d;
    logic [CNT_W-1:0] missed_cnt_q, missed_cnt_d;

    logic [3:0]       ev;
    logic [3:0]       clr;
    logic [3:0]       lost;
    logic             handshake;

    // An event that lands on its own clear re-arms the bit instead of being counted lost.
    always_comb begin
        ev        = EDGE_MODE ? (bus.req & ~req_q) : bus.req;
        handshake = (state_q == PRESENT) && bus.irq_ready;
        clr       = handshake ? (4'b0001 << irq_id_q) : 4'b0000;
        lost      = ev & pend_q & ~clr;
        pend_d    = ev | (pend_q & ~clr);
    end

    always_comb begin
        missed_cnt_d = missed_cnt_q;
        if (bus.clr_cnt) begin
            missed_cnt_d = '0;
        end else if ((|lost) && (missed_cnt_q != {CNT_W{1'b1}})) begin
            missed_cnt_d = missed_cnt_q + CNT_W'(1);
        end
    end

    // Returning to IDLE after every grant lets the encoder see the cleared bit before it picks again.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IDLE: begin
                if (bus.enc_valid) begin
                    irq_id_d = bus.enc_out;
                    state_d  = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.irq_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= 4'b0000;
            pend_q       <= 4'b0000;
            irq_id_q     <= 2'd0;
            missed_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= bus.req;
            pend_q       <= pend_d;
            irq_id_q     <= irq_id_d;
            missed_cnt_q <= missed_cnt_d;
        end
    end

    assign bus.enc_in     = pend_q & ~bus.mask;
    assign bus.irq_valid  = (state_q == PRESENT);
    assign bus.irq_id     = irq_id_q;
    assign bus.missed_cnt = missed_cnt_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed scenarios plus random traffic against an event-level model.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_irq_pending_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       irqReady;
    logic       clrCnt;

    int total;
    int bad;

    irq_pending_ctrl_if #(.CNT_W(8)) bus ();
    irq_pending_ctrl_if #(.CNT_W(2)) bus2 ();

    function automatic logic [1:0] prioEnc(input logic [3:0] v);
        prioEnc = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) prioEnc = 2'(i);
        end
    endfunction

    assign bus.req        = req;
    assign bus.mask       = mask;
    assign bus.irq_ready  = irqReady;
    assign bus.clr_cnt    = clrCnt;
    assign bus.enc_valid  = |bus.enc_in;
    assign bus.enc_out    = prioEnc(bus.enc_in);

    assign bus2.req       = req;
    assign bus2.mask      = mask;
    assign bus2.irq_ready = irqReady;
    assign bus2.clr_cnt   = clrCnt;
    assign bus2.enc_valid = |bus2.enc_in;
    assign bus2.enc_out   = prioEnc(bus2.enc_in);

    irq_pending_ctrl #(.CNT_W(8), .EDGE_MODE(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    irq_pending_ctrl #(.CNT_W(2), .EDGE_MODE(1'b1)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sources pending, whether a grant is on offer, which one, and lost-event tallies.
    bit   mPending [4];
    bit   mPrevReq [4];
    bit   mOffering;
    int   mOffered;
    int   mLost;
    int   mLost2;

    function automatic void modelReset();
        for (int i = 0; i < 4; i++) begin
            mPending[i] = 1'b0;
            mPrevReq[i] = 1'b0;
        end
        mOffering = 1'b0;
        mOffered  = 0;
        mLost     = 0;
        mLost2    = 0;
    endfunction

    function automatic void modelEdge();
        bit newEvent [4];
        bit accepted [4];
        bit anyLost;
        int winner;
        anyLost = 1'b0;
        winner  = -1;
        for (int i = 0; i < 4; i++) begin
            newEvent[i] = req[i] && !mPrevReq[i];
            accepted[i] = mOffering && irqReady && (mOffered == i);
            if (newEvent[i] && mPending[i] && !accepted[i]) anyLost = 1'b1;
            if (mPending[i] && !mask[i]) winner = i;
        end
        if (!mOffering) begin
            if (winner >= 0) begin
                mOffering = 1'b1;
                mOffered  = winner;
            end
        end else if (irqReady) begin
            mOffering = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            mPending[i] = newEvent[i] || (mPending[i] && !accepted[i]);
            mPrevReq[i] = req[i];
        end
        if (clrCnt) begin
            mLost  = 0;
            mLost2 = 0;
        end else if (anyLost) begin
            if (mLost < 255) mLost++;
            if (mLost2 < 3) mLost2++;
        end
    endfunction

    function automatic logic [3:0] modelEncIn();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = mPending[i] && !mask[i];
        return v;
    endfunction

    task automatic applyStimulus();
        @(posedge clk);
        if (!rst) modelEdge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; mask = 4'b0000; irqReady = 1'b0; clrCnt = 1'b0;
        modelReset();
        #3;
        total++;
        if (bus.irq_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b exp=0", bus.irq_valid); end
        total++;
        if (bus.irq_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_id got=%0d exp=0", bus.irq_id); end
        total++;
        if (bus.enc_in !== 4'b0000) begin bad++; $display("[TB] FAIL reset_enc_in got=%b exp=0000", bus.enc_in); end
        total++;
        if (bus.missed_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_missed got=%0d exp=0", bus.missed_cnt); end
        req = 4'b0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        irqReady = 1'b1;
        req = 4'b0100;
        applyStimulus();
        req = 4'b0000;
        total++;
        if (bus.enc_in !== 4'b0100 || bus.irq_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL single_latched enc_in=%b valid=%0b exp enc_in=0100 valid=0", bus.enc_in, bus.irq_valid);
        end
        applyStimulus();
        total++;
        if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd2) begin
            bad++; $display("[TB] FAIL single_present valid=%0b id=%0d exp valid=1 id=2", bus.irq_valid, bus.irq_id);
        end
        applyStimulus();
        total++;
        if (bus.irq_valid !== 1'b0 || bus.enc_in !== 4'b0000) begin
            bad++; $display("[TB] FAIL single_accept valid=%0b enc_in=%b exp valid=0 enc_in=0000", bus.irq_valid, bus.enc_in);
        end
        applyStimulus();
        total++;
        if (bus.irq_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_quiet valid=%0b exp=0", bus.irq_valid); end
    endtask

    task automatic test_back_to_back();
        int grants [$];
        int adjacent;
        bit lastValid;
        adjacent  = 0;
        lastValid = 1'b0;
        irqReady  = 1'b1;
        req = 4'b1011;
        applyStimulus();
        req = 4'b0000;
        for (int c = 0; c < 12; c++) begin
            applyStimulus();
            if (bus.irq_valid === 1'b1) begin
                grants.push_back(int'(bus.irq_id));
                if (lastValid) adjacent++;
            end
            lastValid = (bus.irq_valid === 1'b1);
        end
        total++;
        if (grants.size() != 3) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=3", grants.size()); end
        total++;
        if (grants.size() != 3 || grants[0] != 3 || grants[1] != 1 || grants[2] != 0) begin
            bad++; $display("[TB] FAIL b2b_order got=%p exp='{3,1,0}", grants);
        end
        total++;
        if (adjacent != 0) begin bad++; $display("[TB] FAIL b2b_gap adjacent_valid_cycles=%0d exp=0", adjacent); end
        total++;
        if (bus.enc_in !== 4'b0000) begin bad++; $display("[TB] FAIL b2b_drained enc_in=%b exp=0000", bus.enc_in); end
    endtask

    task automatic test_backpressure();
        int waited;
        irqReady = 1'b0;
        req = 4'b0001;
        applyStimulus();
        req = 4'b0000;
        waited = 0;
        while (bus.irq_valid !== 1'b1 && waited < 4) begin applyStimulus(); waited++; end
        total++;
        if (bus.irq_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_timeout valid=%0b exp=1", bus.irq_valid); end
        for (int c = 0; c < 5; c++) begin
            req = (c == 1) ? 4'b1000 : 4'b0000;
            applyStimulus();
            total++;
            if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd0) begin
                bad++; $display("[TB] FAIL bp_hold cycle=%0d valid=%0b id=%0d exp valid=1 id=0", c, bus.irq_valid, bus.irq_id);
            end
        end
        req = 4'b0000;
        irqReady = 1'b1;
        applyStimulus();
        waited = 0;
        while (bus.irq_valid !== 1'b1 && waited < 4) begin applyStimulus(); waited++; end
        total++;
        if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd3) begin
            bad++; $display("[TB] FAIL bp_next valid=%0b id=%0d exp valid=1 id=3", bus.irq_valid, bus.irq_id);
        end
        applyStimulus();
        applyStimulus();
    endtask

    task automatic test_mask();
        bit seen;
        irqReady = 1'b1;
        mask = 4'b0010;
        req  = 4'b0010;
        applyStimulus();
        req  = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (bus.enc_in !== 4'b0000 || bus.irq_valid !== 1'b0) begin
                bad++; $display("[TB] FAIL mask_hidden enc_in=%b valid=%0b exp enc_in=0000 valid=0", bus.enc_in, bus.irq_valid);
            end
            applyStimulus();
        end
        mask = 4'b0000;
        seen = 1'b0;
        for (int c = 0; c < 2 && !seen; c++) begin
            applyStimulus();
            seen = (bus.irq_valid === 1'b1);
        end
        total++;
        if (!seen || bus.irq_id !== 2'd1) begin
            bad++; $display("[TB] FAIL mask_release valid=%0b id=%0d exp valid=1 id=1", bus.irq_valid, bus.irq_id);
        end
        applyStimulus();
        applyStimulus();
    endtask

    task automatic test_missed();
        irqReady = 1'b0;
        clrCnt = 1'b1;
        applyStimulus();
        clrCnt = 1'b0;
        req = 4'b0100;
        applyStimulus();
        for (int k = 0; k < 3; k++) begin
            req = 4'b0000; applyStimulus();
            req = 4'b0100; applyStimulus();
        end
        total++;
        if (bus.missed_cnt !== 8'd3 || bus2.missed_cnt !== 2'd3) begin
            bad++; $display("[TB] FAIL missed_three got=%0d/%0d exp=3/3", bus.missed_cnt, bus2.missed_cnt);
        end
        req = 4'b0000;
        clrCnt = 1'b1;
        applyStimulus();
        clrCnt = 1'b0;
        total++;
        if (bus.missed_cnt !== 8'd0 || bus2.missed_cnt !== 2'd0) begin
            bad++; $display("[TB] FAIL missed_clear got=%0d/%0d exp=0/0", bus.missed_cnt, bus2.missed_cnt);
        end
        for (int k = 0; k < 5; k++) begin
            req = 4'b0100; applyStimulus();
            req = 4'b0000; applyStimulus();
        end
        total++;
        if (bus.missed_cnt !== 8'd5 || bus2.missed_cnt !== 2'd3) begin
            bad++; $display("[TB] FAIL missed_saturate got=%0d/%0d exp=5/3", bus.missed_cnt, bus2.missed_cnt);
        end
        total++;
        if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd2) begin
            bad++; $display("[TB] FAIL missed_held valid=%0b id=%0d exp valid=1 id=2", bus.irq_valid, bus.irq_id);
        end
        irqReady = 1'b1;
        repeat (3) applyStimulus();
    endtask

    task automatic test_reset_mid();
        irqReady = 1'b0;
        req = 4'b1100;
        applyStimulus();
        req = 4'b0000;
        applyStimulus();
        total++;
        if (bus.irq_valid !== 1'b1 || bus.enc_in !== 4'b1100) begin
            bad++; $display("[TB] FAIL rstmid_setup valid=%0b enc_in=%b exp valid=1 enc_in=1100", bus.irq_valid, bus.enc_in);
        end
        #2;
        rst = 1'b1;
        req = 4'b0001;
        modelReset();
        #1;
        total++;
        if (bus.irq_valid !== 1'b0 || bus.irq_id !== 2'd0 || bus.enc_in !== 4'b0000 || bus.missed_cnt !== 8'd0) begin
            bad++; $display("[TB] FAIL rstmid_clear valid=%0b id=%0d enc_in=%b cnt=%0d exp all 0",
                            bus.irq_valid, bus.irq_id, bus.enc_in, bus.missed_cnt);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus();
        total++;
        if (bus.irq_valid !== 1'b0 || bus.enc_in !== 4'b0001) begin
            bad++; $display("[TB] FAIL rstmid_edge1 valid=%0b enc_in=%b exp valid=0 enc_in=0001", bus.irq_valid, bus.enc_in);
        end
        applyStimulus();
        total++;
        if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'd0) begin
            bad++; $display("[TB] FAIL rstmid_edge2 valid=%0b id=%0d exp valid=1 id=0", bus.irq_valid, bus.irq_id);
        end
        req = 4'b0000;
        irqReady = 1'b1;
        repeat (2) applyStimulus();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req      = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            irqReady = ($urandom_range(0, 2) != 0);
            clrCnt   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15));
            applyStimulus();
            total++;
            if (bus.irq_valid !== mOffering) begin
                bad++; $display("[TB] FAIL rand_valid cycle=%0d got=%0b exp=%0b", c, bus.irq_valid, mOffering);
            end
            if (mOffering) begin
                total++;
                if (bus.irq_id !== 2'(mOffered)) begin
                    bad++; $display("[TB] FAIL rand_id cycle=%0d got=%0d exp=%0d", c, bus.irq_id, mOffered);
                end
            end
            total++;
            if (bus.enc_in !== modelEncIn()) begin
                bad++; $display("[TB] FAIL rand_enc_in cycle=%0d got=%b exp=%b", c, bus.enc_in, modelEncIn());
            end
            total++;
            if (bus.missed_cnt !== 8'(mLost) || bus2.missed_cnt !== 2'(mLost2)) begin
                bad++; $display("[TB] FAIL rand_missed cycle=%0d got=%0d/%0d exp=%0d/%0d",
                                c, bus.missed_cnt, bus2.missed_cnt, mLost, mLost2);
            end
        end
        req = 4'b0000; mask = 4'b0000; clrCnt = 1'b0; irqReady = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mask();
        test_missed();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
